// File: rtl/instruction_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer_if
// Description : Control, memory-read and CPU-side signals of the instruction
//               sequencer, bundled with sequencer (master) and environment
//               (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_sequencer_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 32
);
    logic                   start_in;
    logic [ADDR_WIDTH:0]    program_length_in;
    logic                   stall_in;
    logic [ADDR_WIDTH-1:0]  mem_addr_out;
    logic                   mem_rd_en_out;
    logic [INSTR_WIDTH-1:0] mem_data_in;
    logic [INSTR_WIDTH-1:0] current_instruction_out;
    logic                   instr_valid_out;
    logic [ADDR_WIDTH-1:0]  pc_out;
    logic                   busy_out;
    logic                   done_out;

    modport master (
        input  start_in, program_length_in, stall_in, mem_data_in,
        output mem_addr_out, mem_rd_en_out, current_instruction_out,
               instr_valid_out, pc_out, busy_out, done_out
    );

    modport slave (
        output start_in, program_length_in, stall_in, mem_data_in,
        input  mem_addr_out, mem_rd_en_out, current_instruction_out,
               instr_valid_out, pc_out, busy_out, done_out
    );
endinterface
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Fetches a program from a 1-cycle-latency instruction memory
//               and presents one instruction per cycle to the CPU, with
//               stall back-pressure (1-entry skid), HALT early termination
//               and a done level.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter int          PROGRAM_DEPTH = 64,
    parameter int          ADDR_WIDTH    = 6,
    parameter int          INSTR_WIDTH   = 32,
    parameter logic [7:0]  HALT_OPCODE   = 8'hFF
) (
    input  wire logic              clock_in,
    input  wire logic              rst_n_in,
    instruction_sequencer_if.master bus
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(PROGRAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH:0]    r_len;
    logic [ADDR_WIDTH:0]    r_fp;
    logic                   r_halt_seen;
    logic                   r_inflight;
    logic [ADDR_WIDTH-1:0]  r_inflight_addr;
    logic                   r_skid_valid;
    logic [INSTR_WIDTH-1:0] r_skid_data;
    logic [ADDR_WIDTH-1:0]  r_skid_addr;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_valid;
    logic [ADDR_WIDTH-1:0]  r_pc;

    logic [ADDR_WIDTH:0]    w_len_capped;
    logic                   w_strobe;
    logic                   w_load_valid;
    logic [INSTR_WIDTH-1:0] w_load_data;
    logic [ADDR_WIDTH-1:0]  w_load_addr;
    logic                   w_load_halt;
    logic                   w_pres_halt;
    logic                   w_last;

    // Lengths beyond the memory depth run the whole memory once.
    assign w_len_capped = (bus.program_length_in > c_depth) ? c_depth : bus.program_length_in;

    // Strobe is gated by reset so an abort drops the read immediately.
    assign w_strobe = rst_n_in && (r_state == S_RUN) && !bus.stall_in
                      && (r_fp < r_len) && !r_halt_seen;

    // The skid entry is older than any read returning now, so it goes first.
    assign w_load_valid = r_skid_valid || r_inflight;
    assign w_load_data  = r_skid_valid ? r_skid_data : bus.mem_data_in;
    assign w_load_addr  = r_skid_valid ? r_skid_addr : r_inflight_addr;
    assign w_load_halt  = (w_load_data[INSTR_WIDTH-1 -: 8] == HALT_OPCODE);

    // The presented word is the final one if it is a HALT or the last address.
    assign w_pres_halt = (r_instr[INSTR_WIDTH-1 -: 8] == HALT_OPCODE);
    assign w_last      = r_valid && (w_pres_halt || (({1'b0, r_pc} + c_one) == r_len));

    // Sequencer state, fetch pointer, skid register and output register.
    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state         <= S_IDLE;
            r_len           <= '0;
            r_fp            <= '0;
            r_halt_seen     <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_skid_valid    <= 1'b0;
            r_skid_data     <= '0;
            r_skid_addr     <= '0;
            r_instr         <= '0;
            r_valid         <= 1'b0;
            r_pc            <= '0;
        end else begin
            r_inflight <= w_strobe;
            if (w_strobe) begin
                r_inflight_addr <= r_fp[ADDR_WIDTH-1:0];
                r_fp            <= r_fp + c_one;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_in) begin
                        r_len        <= w_len_capped;
                        r_fp         <= '0;
                        r_halt_seen  <= 1'b0;
                        r_skid_valid <= 1'b0;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    // Fetching is over; later assignments may still pick DONE.
                    if (r_state == S_RUN && (r_halt_seen || r_fp >= r_len)) begin
                        r_state <= S_DRAIN;
                    end
                    if (r_len == '0) begin
                        r_state <= S_DONE;
                    end else if (bus.stall_in) begin
                        // Output holds; a read already in flight parks in the skid.
                        if (r_inflight) begin
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= bus.mem_data_in;
                            r_skid_addr  <= r_inflight_addr;
                        end
                    end else if (w_last) begin
                        // Anything fetched past the end is discarded here.
                        r_state      <= S_DONE;
                        r_valid      <= 1'b0;
                        r_instr      <= '0;
                        r_pc         <= '0;
                        r_skid_valid <= 1'b0;
                    end else begin
                        r_valid      <= w_load_valid;
                        r_instr      <= w_load_valid ? w_load_data : '0;
                        r_skid_valid <= 1'b0;
                        if (w_load_valid) begin
                            r_pc <= w_load_addr;
                            if (w_load_halt) begin
                                r_halt_seen <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr_out            = r_fp[ADDR_WIDTH-1:0];
    assign bus.mem_rd_en_out           = w_strobe;
    assign bus.current_instruction_out = r_instr;
    assign bus.instr_valid_out         = r_valid;
    assign bus.pc_out                  = r_pc;
    assign bus.busy_out                = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done_out                = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Self-checking bench for instruction_sequencer: a memory
//               model, a queue-based scoreboard fed by a program-level
//               reference model, and directed cycle checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

    localparam int MAXC = 512;

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [64];
    exp_t        exp_q [$];
    logic        done_due = 1'b0;

    logic        lg_rd    [MAXC];
    logic [5:0]  lg_addr  [MAXC];
    logic        lg_valid [MAXC];
    logic [31:0] lg_instr [MAXC];
    logic [5:0]  lg_pc    [MAXC];
    logic        lg_done  [MAXC];

    instruction_sequencer_if #(.ADDR_WIDTH(6), .INSTR_WIDTH(32)) bus ();

    instruction_sequencer #(
        .PROGRAM_DEPTH(64), .ADDR_WIDTH(6), .INSTR_WIDTH(32), .HALT_OPCODE(8'hFF)
    ) dut (
        .clock_in (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd_en_out) bus.mem_data_in <= mem[bus.mem_addr_out];
        else                   bus.mem_data_in <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Program-level model: addresses 0..min(len,64)-1 in order, stopping after a HALT word.
    task automatic model(input int len, output int l, output int h);
        l = (len > 64) ? 64 : len;
        h = -1;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back('{instr: mem[i], pc: 6'(i)});
            if (mem[i][31:24] == 8'hFF) begin
                h = i;
                break;
            end
        end
    endtask

    // Monitor: every accepted presentation is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done_due = 1'b0;
        end else begin
            if (done_due) begin
                chk("done_after_last", {bus.done_out, bus.instr_valid_out, bus.current_instruction_out},
                    {1'b1, 1'b0, 32'h0});
                done_due = 1'b0;
            end
            if (!bus.instr_valid_out) chk("nop_when_invalid", bus.current_instruction_out, 0);
            if (bus.stall_in) chk("no_strobe_in_stall", bus.mem_rd_en_out, 0);
            if (bus.instr_valid_out && !bus.stall_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr actual=%0h pc=%0d required=none",
                             bus.current_instruction_out, bus.pc_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", bus.current_instruction_out, e.instr);
                    chk("pc", bus.pc_out, e.pc);
                    if (exp_q.size() == 0) done_due = 1'b1;
                end
            end
        end
    end

    task automatic sample(input int c);
        lg_rd[c]    = bus.mem_rd_en_out;
        lg_addr[c]  = bus.mem_addr_out;
        lg_valid[c] = bus.instr_valid_out;
        lg_instr[c] = bus.current_instruction_out;
        lg_pc[c]    = bus.pc_out;
        lg_done[c]  = bus.done_out;
    endtask

    // One program run: start at cycle 0, then run until done or timeout.
    task automatic run_prog(input int len, input int stall_pct, input bit dir_stall,
                            input int pulse_cyc, output int strobes, output int l, output int h);
        int  cyc;
        bit  fin;
        model(len, l, h);
        @(posedge clk); #1;
        bus.start_in          = 1'b1;
        bus.program_length_in = 7'(len);
        bus.stall_in          = 1'b0;
        cyc = 0;
        fin = 1'b0;
        @(negedge clk);
        sample(0);
        strobes = int'(bus.mem_rd_en_out);
        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            bus.start_in = (cyc == pulse_cyc);
            if (cyc == pulse_cyc) bus.program_length_in = 7'd1;
            bus.stall_in = dir_stall ? (cyc == 4 || cyc == 5) : ($urandom_range(0, 99) < stall_pct);
            @(negedge clk);
            sample(cyc);
            strobes += int'(bus.mem_rd_en_out);
            if (bus.done_out) begin
                fin = 1'b1;
            end else if (cyc >= MAXC - 1) begin
                checks++;
                errors++;
                $display("FAIL run_timeout actual=not_done required=done len=%0d", len);
                fin = 1'b1;
            end
        end
        bus.stall_in = 1'b0;
        bus.start_in = 1'b0;
        chk("queue_drained", 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    function automatic logic [95:0] all_outs();
        return {48'h0, bus.mem_addr_out, bus.mem_rd_en_out, bus.instr_valid_out, bus.pc_out,
                bus.busy_out, bus.done_out, bus.current_instruction_out[31:0]} | 96'(0);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 11) == 0) w[31:24] = 8'hFF;
        else if (w[31:24] == 8'hFF)     w[31:24] = 8'h7F;
        return w;
    endfunction

    initial begin
        int s, l, h;
        bit ok;
        bus.start_in          = 1'b0;
        bus.program_length_in = '0;
        bus.stall_in          = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0100 + 32'(i);
        for (int i = 0; i < 4; i++)  mem[i] = 32'h0000_0011 + 32'(i);

        // Power-up reset asserted mid-clock: outputs clear before any edge.
        #2 rst_n = 1'b0;
        #1 chk("reset_async_outputs", all_outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_start", all_outs(), 0);
        end

        // Basic LEN=4 timing.
        run_prog(4, 0, 1'b0, -1, s, l, h);
        chk("c0_no_strobe", lg_rd[0], 0);
        for (int k = 1; k <= 4; k++) chk("strobe_addr", {lg_rd[k], lg_addr[k]}, {1'b1, 6'(k - 1)});
        chk("c5_no_strobe", lg_rd[5], 0);
        for (int k = 3; k <= 6; k++)
            chk("present", {lg_valid[k], lg_instr[k], lg_pc[k]}, {1'b1, 32'h11 + 32'(k - 3), 6'(k - 3)});
        chk("c7_done", {lg_done[7], lg_valid[7], lg_instr[7]}, {1'b1, 1'b0, 32'h0});
        chk("strobes_len4", s, 4);

        // Same program with stall in cycles 4-5 (restart from DONE).
        run_prog(4, 0, 1'b1, -1, s, l, h);
        for (int k = 4; k <= 6; k++) chk("stall_hold", {lg_valid[k], lg_instr[k]}, {1'b1, 32'h12});
        chk("skid_first", {lg_valid[7], lg_instr[7]}, {1'b1, 32'h13});
        chk("after_skid", {lg_valid[8], lg_instr[8], lg_pc[8]}, {1'b1, 32'h14, 6'd3});
        chk("stall_done", {lg_done[8], lg_done[9]}, 2'b01);
        chk("strobes_stall", s, 4);

        // HALT at word 2, LEN=8.
        mem[2] = 32'hFF00_0000;
        mem[3] = 32'h0000_0EEE;
        run_prog(8, 0, 1'b0, -1, s, l, h);
        chk("halt_strobes_le4", (s <= 4) && (s >= 3), 1);
        mem[2] = 32'h0000_0013;
        mem[3] = 32'h0000_0014;

        // LEN=0.
        run_prog(0, 0, 1'b0, -1, s, l, h);
        chk("len0_strobes", s, 0);
        chk("len0_done_timing", {lg_done[1], lg_done[2]}, 2'b01);

        // Restart from DONE with LEN=2.
        run_prog(2, 0, 1'b0, -1, s, l, h);
        chk("restart_first", {lg_valid[3], lg_instr[3], lg_pc[3]}, {1'b1, 32'h11, 6'd0});
        chk("restart_strobes", s, 2);

        // start pulsed while busy (with a different length) is ignored.
        run_prog(6, 0, 1'b0, 3, s, l, h);
        chk("busy_start_strobes", s, 6);

        // Randomized programs, lengths (including above depth) and stalls.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = rand_word();
            run_prog($urandom_range(0, 70), 35, 1'b0, (r % 3 == 0) ? 2 : -1, s, l, h);
            if (h < 0) ok = (s == l);
            else       ok = (s >= h + 1) && (s <= h + 2) && (s <= l);
            if (!ok) $display("FAIL rand_strobes actual=%0d required_len=%0d halt_at=%0d", s, l, h);
            chk("rand_strobe_count", ok, 1);
        end

        // Reset in the middle of a run aborts immediately.
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_2000 + 32'(i);
        model(8, l, h);
        @(posedge clk); #1;
        bus.start_in          = 1'b1;
        bus.program_length_in = 7'd8;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_reset_busy", {bus.busy_out, bus.mem_rd_en_out}, 2'b11);
        rst_n = 1'b0;
        #1 chk("midrun_reset_outputs", all_outs(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_idle", all_outs(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
